axis2axi_resp_depacketizer: RTL and testbench

- Receive end of the mesh response network: consumes response packets leaving a router's HOME_RESP output port and rebuilds AXI B and R channel beats for the local initiator.
- Inverse of the response-side packetizer inside the node bridge. Sits between the router HOME_RESP output and the initiator-side AXI B/R interface.
- Validates each packet's header: type, destination and packet framing. Malformed or misrouted packets are drained and counted.

---
 rtl/noc_pkt_pkg.sv | 35 +++
 rtl/axi_out_reg.sv | 36 +++
 rtl/axis2axi_resp_depacketizer.sv | 146 ++++++++++++++
 tb/tb_axis2axi_resp_depacketizer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkt_pkg.sv
// Shared mesh packet definitions: type codes, header field offsets and the
// response-side depacketizer state encoding.
package noc_pkt_pkg;

  localparam logic [7:0] PKT_AW = 8'h01;
  localparam logic [7:0] PKT_B  = 8'h02;
  localparam logic [7:0] PKT_W  = 8'h03;
  localparam logic [7:0] PKT_R  = 8'h04;
  localparam logic [7:0] PKT_AR = 8'h05;

  // Header layout, LSB first: type[7:0], dst_x, dst_y, src_x, src_y
  function automatic int hdr_dst_x_off();
    return 8;
  endfunction

  function automatic int hdr_dst_y_off(input int xw);
    return 8 + xw;
  endfunction

  function automatic int hdr_src_x_off(input int xw, input int yw);
    return 8 + xw + yw;
  endfunction

  function automatic int hdr_src_y_off(input int xw, input int yw);
    return 8 + 2 * xw + yw;
  endfunction

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    B_PAY = 2'd1,
    R_PAY = 2'd2,
    DROP  = 2'd3
  } resp_state_t;

endpackage

// File: rtl/axi_out_reg.sv
// One-entry valid/ready output register; a new word may be loaded in the
// same cycle the current one drains.
module axi_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         can_load,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         vld_p1;
  logic [W-1:0] data_p1;

  assign can_load = !vld_p1 || out_rdy;
  assign out_vld  = vld_p1;
  assign out_data = data_p1;

  // Stage p1: registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
    end else if (out_rdy) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/axis2axi_resp_depacketizer.sv
// Rebuilds AXI B/R beats from response packets on the router HOME_RESP port;
// misrouted or malformed packets are drained and counted.
module axis2axi_resp_depacketizer
  import noc_pkt_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int ID_W_WIDTH         = 5,
  parameter int ID_R_WIDTH         = 5,
  parameter int AXIS_CHANNEL_WIDTH = 40,
  parameter int MAX_ROUTERS_X      = 4,
  parameter int MAX_ROUTERS_Y      = 4,
  parameter int ROUTER_X           = 0,
  parameter int ROUTER_Y           = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          s_axis_tvalid_i,
  output logic                          s_axis_tready_o,
  input  logic [AXIS_CHANNEL_WIDTH-1:0] s_axis_tdata_i,
  input  logic                          s_axis_tlast_i,
  output logic                          m_bvalid_o,
  input  logic                          m_bready_i,
  output logic [ID_W_WIDTH-1:0]         m_bid_o,
  output logic [1:0]                    m_bresp_o,
  output logic                          m_rvalid_o,
  input  logic                          m_rready_i,
  output logic [ID_R_WIDTH-1:0]         m_rid_o,
  output logic [DATA_WIDTH-1:0]         m_rdata_o,
  output logic [1:0]                    m_rresp_o,
  output logic                          m_rlast_o,
  output logic [7:0]                    err_cnt_o
);

  localparam int XW     = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
  localparam int YW     = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
  localparam int DX_OFF = hdr_dst_x_off();
  localparam int DY_OFF = hdr_dst_y_off(XW);
  localparam int RW     = 1 + ID_R_WIDTH + DATA_WIDTH;
  localparam logic [XW-1:0] MY_X = ROUTER_X[XW-1:0];
  localparam logic [YW-1:0] MY_Y = ROUTER_Y[YW-1:0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  resp_state_t state, state_nxt;
  logic        tready, b_load, r_load, err_inc;
  logic        b_can_load, r_can_load, dst_ok;
  logic [7:0]  pkt_type;
  logic [RW-1:0] r_word;
  logic        unused_tdata;

  assign pkt_type = s_axis_tdata_i[7:0];
  assign dst_ok   = (s_axis_tdata_i[DX_OFF +: XW] == MY_X) &&
                    (s_axis_tdata_i[DY_OFF +: YW] == MY_Y);
  assign unused_tdata    = ^s_axis_tdata_i;
  assign s_axis_tready_o = tready;
  assign m_bresp_o = 2'b00;
  assign m_rresp_o = 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= HDR;
      err_cnt_o <= 8'h00;
    end else begin
      state <= state_nxt;
      if (err_inc) err_cnt_o <= sat_inc(err_cnt_o);
    end
  end

  always_comb begin
    state_nxt = state;
    tready    = 1'b0;
    b_load    = 1'b0;
    r_load    = 1'b0;
    err_inc   = 1'b0;
    case (state)
      HDR: begin
        tready = 1'b1;
        if (s_axis_tvalid_i) begin
          if (s_axis_tlast_i) begin
            err_inc = 1'b1;
          end else if (pkt_type == PKT_B && dst_ok) begin
            state_nxt = B_PAY;
          end else if (pkt_type == PKT_R && dst_ok) begin
            state_nxt = R_PAY;
          end else begin
            state_nxt = DROP;
            err_inc   = 1'b1;
          end
        end
      end
      B_PAY: begin
        tready = b_can_load;
        if (s_axis_tvalid_i && tready) begin
          b_load = 1'b1;
          if (s_axis_tlast_i) begin
            state_nxt = HDR;
          end else begin
            // B is still issued; the surplus flits are drained and counted
            state_nxt = DROP;
            err_inc   = 1'b1;
          end
        end
      end
      R_PAY: begin
        tready = r_can_load;
        if (s_axis_tvalid_i && tready) begin
          r_load = 1'b1;
          if (s_axis_tlast_i) state_nxt = HDR;
        end
      end
      default: begin
        tready = 1'b1;
        if (s_axis_tvalid_i && s_axis_tlast_i) state_nxt = HDR;
      end
    endcase
  end

  axi_out_reg #(.W(ID_W_WIDTH)) u_b_reg (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (b_load),
    .load_data (s_axis_tdata_i[ID_W_WIDTH-1:0]),
    .can_load  (b_can_load),
    .out_vld   (m_bvalid_o),
    .out_rdy   (m_bready_i),
    .out_data  (m_bid_o)
  );

  axi_out_reg #(.W(RW)) u_r_reg (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (r_load),
    .load_data ({s_axis_tlast_i, s_axis_tdata_i[DATA_WIDTH+ID_R_WIDTH-1:0]}),
    .can_load  (r_can_load),
    .out_vld   (m_rvalid_o),
    .out_rdy   (m_rready_i),
    .out_data  (r_word)
  );

  assign m_rlast_o = r_word[RW-1];
  assign m_rid_o   = r_word[DATA_WIDTH +: ID_R_WIDTH];
  assign m_rdata_o = r_word[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis2axi_resp_depacketizer.sv
// Scoreboard bench for the response depacketizer: expected B/R beats are
// queued as flits are driven and retired as the AXI side hands them off.
module tb_axis2axi_resp_depacketizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [39:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        m_bvalid, m_bready = 1'b1;
  logic [4:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_rvalid, m_rready = 1'b1;
  logic [4:0]  m_rid;
  logic [7:0]  m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;
  int stalls = 0;
  int exp_err = 0;
  bit bp_done;

  logic [4:0]  b_q[$];
  logic [13:0] r_q[$];   // {last, id, data}

  always #5 clk = ~clk;

  axis2axi_resp_depacketizer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tlast_i  (s_tlast),
    .m_bvalid_o      (m_bvalid),
    .m_bready_i      (m_bready),
    .m_bid_o         (m_bid),
    .m_bresp_o       (m_bresp),
    .m_rvalid_o      (m_rvalid),
    .m_rready_i      (m_rready),
    .m_rid_o         (m_rid),
    .m_rdata_o       (m_rdata),
    .m_rresp_o       (m_rresp),
    .m_rlast_o       (m_rlast),
    .err_cnt_o       (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; a valid&&ready seen here
  // completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_bvalid && m_bready) begin
        if (b_q.size() == 0) chk("b_extra", 32'd1, 32'd0);
        else begin
          chk("bid", m_bid, b_q.pop_front());
          chk("bresp", m_bresp, 2'b00);
        end
      end
      if (m_rvalid && m_rready) begin
        if (r_q.size() == 0) chk("r_extra", 32'd1, 32'd0);
        else begin
          chk("rbeat", {m_rlast, m_rid, m_rdata}, r_q.pop_front());
          chk("rresp", m_rresp, 2'b00);
        end
      end
    end
  end

  task automatic send_flit(input logic [39:0] d, input logic l);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!s_tready) chk("tready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_r(input logic [4:0] id, input logic [7:0] data, input logic l);
    r_q.push_back({l, id, data});
    send_flit({27'd0, id, data}, l);
  endtask

  task automatic send_r_burst4(input logic [4:0] id, input logic [7:0] base);
    send_flit(40'h0004, 1'b0);
    for (int i = 0; i < 4; i++) send_r(id, base + 8'(i), (i == 3));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_bvalid", m_bvalid, 1'b0);
    chk("rst_rvalid", m_rvalid, 1'b0);
    chk("rst_out", {m_bid, m_rid, m_rdata, m_rlast}, 19'd0);
    chk("rst_err", err_cnt, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // B packet to (0,0) with one-cycle output latency
    send_flit(40'h0002, 1'b0);
    b_q.push_back(5'h13);
    s_tvalid = 1'b1; s_tdata = 40'h13; s_tlast = 1'b1;
    @(negedge clk);
    chk("b_pre_valid", m_bvalid, 1'b0);
    chk("b_tready", s_tready, 1'b1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("b_lat_valid", m_bvalid, 1'b1);
    chk("b_lat_id", m_bid, 5'h13);
    idle(2);
    chk("b_cleared", m_bvalid, 1'b0);
    chk("err_after_b", err_cnt, 8'(exp_err));

    // R burst at full rate
    stalls = 0;
    send_r_burst4(5'd3, 8'hA0);
    chk("r_stalls", 32'(stalls), 32'd0);
    idle(3);
    chk("r_drained", 32'(r_q.size()), 32'd0);

    // R burst under backpressure
    m_rready = 1'b0;
    bp_done  = 1'b0;
    fork
      begin
        send_r_burst4(5'd3, 8'hA0);
        bp_done = 1'b1;
      end
    join_none
    n = 0;
    @(negedge clk);
    while (!m_rvalid && n < 50) begin n++; @(negedge clk); end
    chk("bp_rvalid_seen", m_rvalid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rvalid", m_rvalid, 1'b1);
      chk("bp_rdata", m_rdata, 8'hA0);
      chk("bp_tready", s_tready, 1'b0);
    end
    @(posedge clk);
    #1;
    m_rready = 1'b1;
    n = 0;
    while (!bp_done && n < 50) begin n++; @(posedge clk); end
    chk("bp_done", bp_done, 1'b1);
    idle(3);
    chk("bp_drained", 32'(r_q.size()), 32'd0);

    // Misrouted and unknown-type packets
    send_flit(40'h0102, 1'b0);
    send_flit(40'h0013, 1'b0);
    send_flit(40'h0014, 1'b1);
    exp_err++;
    idle(2);
    chk("err_misroute", err_cnt, 8'(exp_err));
    send_flit(40'h007F, 1'b0);
    send_flit(40'h0001, 1'b1);
    exp_err++;
    idle(2);
    chk("err_unknown", err_cnt, 8'(exp_err));

    // Framing errors: single-flit header, then B with three payload flits
    send_flit(40'h0002, 1'b1);
    exp_err++;
    idle(1);
    chk("err_hdr_last", err_cnt, 8'(exp_err));
    send_flit(40'h0002, 1'b0);
    b_q.push_back(5'h05);
    send_flit(40'h0005, 1'b0);
    send_flit(40'h0006, 1'b0);
    send_flit(40'h0007, 1'b1);
    exp_err++;
    idle(3);
    chk("err_b_extra", err_cnt, 8'(exp_err));
    chk("b_drained", 32'(b_q.size()), 32'd0);
    // Header path must be back in HDR: a fresh B packet decodes cleanly
    send_flit(40'h0002, 1'b0);
    b_q.push_back(5'h1F);
    send_flit(40'h001F, 1'b1);
    idle(3);
    chk("b_after_drop", 32'(b_q.size()), 32'd0);

    // Reset in the middle of an R burst
    send_flit(40'h0004, 1'b0);
    send_r(5'd3, 8'hA0, 1'b0);
    send_r(5'd3, 8'hA1, 1'b0);
    m_rready = 1'b0;
    @(negedge clk);
    chk("mid_rvalid", m_rvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    r_q.delete();
    exp_err = 0;
    chk("rst_mid_rvalid", m_rvalid, 1'b0);
    chk("rst_mid_tready", s_tready, 1'b1);
    chk("rst_mid_err", err_cnt, 8'h00);
    m_rready = 1'b1;
    send_flit({27'd0, 5'd3, 8'hA2}, 1'b0);
    send_flit({27'd0, 5'd3, 8'hA3}, 1'b1);
    exp_err++;
    idle(2);
    chk("err_after_rst", err_cnt, 8'(exp_err));

    // Saturation of the drop counter
    while (exp_err < 255) begin
      send_flit(40'h0002, 1'b1);
      exp_err++;
    end
    idle(1);
    chk("err_255", err_cnt, 8'hFF);
    while (exp_err < 300) begin
      send_flit(40'h0004, 1'b1);
      exp_err++;
    end
    idle(2);
    chk("err_sat", err_cnt, 8'hFF);
    chk("no_stray_r", m_rvalid, 1'b0);
    chk("no_stray_b", m_bvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
